pwm_dac: RTL

- Output stage of the DDS datapath. Sits directly downstream of the sequential amplitude multiplier.
- Captures each scaled product, rounds and saturates it to a W-bit duty code, and drives a free-running single-bit PWM output.
- The output feeds an external RC filter.
- A double-buffered duty register ensures duty changes only at PWM period boundaries, so no period is ever truncated.

---
 rtl/pwm_dac.sv | 98 +++++++++
 1 files changed

// File: rtl/pwm_dac.sv
// PWM output stage: rounds/saturates multiplier products to a W-bit duty code
// and drives a free-running PWM whose duty only changes at period boundaries.
module pwm_dac #(
  parameter int M = 12,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2*M-1:0]   prod_in,
  input  logic             prod_valid,
  output logic             pwm_out,
  output logic [W-1:0]     duty,
  output logic             period_start,
  output logic             overrun
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] pending_q, pending_d;
  logic         pending_full_q, pending_full_d;
  logic [W-1:0] duty_q, duty_d;
  logic         pwm_q, pwm_d;
  logic         period_start_q, period_start_d;
  logic         overrun_q, overrun_d;

  logic [W:0]   code_wide_s;
  logic [W-1:0] code_s;
  logic         wrap_s;

  // Round half up on the first discarded bit; only the all-ones top slice can overflow.
  always_comb begin
    code_wide_s = {1'b0, prod_in[2*M-1 -: W]} + {{W{1'b0}}, prod_in[2*M-W-1]};
    if (code_wide_s[W]) begin
      code_s = {W{1'b1}};
    end else begin
      code_s = code_wide_s[W-1:0];
    end
  end

  always_comb begin
    wrap_s         = (cnt_q == {W{1'b1}});
    cnt_d          = cnt_q + {{(W-1){1'b0}}, 1'b1};
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    duty_d         = duty_q;
    overrun_d      = 1'b0;

    if (wrap_s) begin
      // A strobe landing on the wrap edge bypasses the pending buffer entirely.
      if (prod_valid) begin
        duty_d         = code_s;
        pending_full_d = 1'b0;
      end else if (pending_full_q) begin
        duty_d         = pending_q;
        pending_full_d = 1'b0;
      end else begin
        duty_d         = duty_q;
      end
    end else begin
      if (prod_valid) begin
        pending_d      = code_s;
        pending_full_d = 1'b1;
        overrun_d      = pending_full_q;
      end else begin
        pending_d      = pending_q;
      end
    end

    // Outputs are registered from next-state values so they line up with cnt.
    pwm_d          = (cnt_d < duty_d);
    period_start_d = (cnt_d == {W{1'b0}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= {W{1'b0}};
      pending_q      <= {W{1'b0}};
      pending_full_q <= 1'b0;
      duty_q         <= {W{1'b0}};
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      duty_q         <= duty_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      overrun_q      <= overrun_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign duty         = duty_q;
  assign period_start = period_start_q;
  assign overrun      = overrun_q;

endmodule
